// File: rtl/mux_arb_pkg.sv
// Shared arbitration types and helpers for the routing-fabric arbiters.
// Holds the FSM state encoding and the rotate-priority select function.
package mux_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Widest request vector the select function handles; arbiters zero-extend into it.
    localparam int unsigned MAX_REQ = 64;
    localparam int unsigned IDX_W   = 6;

    typedef enum logic [0:0] {
        ARB_IDLE  = ST_IDLE,
        ARB_GRANT = ST_GRANT
    } arb_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req_vec at or after start, wrapping at n; bits >= n are ignored.
    function automatic rr_pick_t rr_select(input logic [MAX_REQ-1:0] req_vec,
                                           input int unsigned         n,
                                           input int unsigned         start);
        rr_pick_t    pick;
        int unsigned j;
        pick.found = 1'b0;
        pick.idx   = {IDX_W{1'b0}};
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            j = start + i;
            if (j >= n) begin
                j = j - n;
            end
            if ((i < n) && !pick.found && req_vec[IDX_W'(j)]) begin
                pick.found = 1'b1;
                pick.idx   = IDX_W'(j);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester-side bundle of the time-shared mux: requests, data bits and the
// grant/select/data results returned by the arbiter.
interface mux_rr_arbiter_if #(
    parameter int SEL    = 4,
    parameter int INPUTS = 16
);
    logic [INPUTS-1:0] req;
    logic [INPUTS-1:0] data_in;
    logic [INPUTS-1:0] grant;
    logic              grant_valid;
    logic [SEL-1:0]    sel;
    logic              data_out;

    modport master (
        output req,
        output data_in,
        input  grant,
        input  grant_valid,
        input  sel,
        input  data_out
    );

    modport slave (
        input  req,
        input  data_in,
        output grant,
        output grant_valid,
        output sel,
        output data_out
    );
endinterface

// File: rtl/mux_rr_arbiter_mux.sv
// The fabric's plain binary-select mux: one data bit per input, sel picks which.
module mux #(
    parameter int SEL    = 4,
    parameter int INPUTS = 16
) (
    input  logic [SEL-1:0]    sel,
    input  logic [INPUTS-1:0] data_in,
    output logic              data_out
);
    assign data_out = data_in[sel];
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared mux select line: one-hot grant, bounded hold
// time per grant and back-to-back handover to the next pending requester.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int SEL      = 4,
    parameter int INPUTS   = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           reset,
    mux_rr_arbiter_if.slave bus
);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    if (INPUTS > (2 ** SEL)) begin : g_chk_sel
        $error("mux_rr_arbiter: INPUTS exceeds 2**SEL");
    end
    if (INPUTS < 2) begin : g_chk_min
        $error("mux_rr_arbiter: INPUTS must be at least 2");
    end
    if (INPUTS > MAX_REQ) begin : g_chk_max
        $error("mux_rr_arbiter: INPUTS exceeds the select function width");
    end
    if (MAX_HOLD < 1) begin : g_chk_hold
        $error("mux_rr_arbiter: MAX_HOLD must be at least 1");
    end

    arb_state_e        state_r;
    logic [SEL-1:0]    ptr_r;
    logic [SEL-1:0]    sel_r;
    logic [INPUTS-1:0] grant_r;
    logic              grant_valid_r;
    logic [HOLD_W-1:0] hold_cnt_r;

    logic [SEL-1:0]    next_ptr_s;
    logic [SEL-1:0]    start_s;
    rr_pick_t          pick_s;
    logic [SEL-1:0]    pick_sel_s;
    logic [INPUTS-1:0] pick_onehot_s;
    logic              hold_s;
    logic              mux_out_s;

    // Search start and hold decision; on release the search begins just past the holder.
    always_comb begin
        next_ptr_s = (sel_r == SEL'(INPUTS - 1)) ? {SEL{1'b0}} : (sel_r + SEL'(1));
        if (state_r == ARB_GRANT) begin
            start_s = next_ptr_s;
        end else begin
            start_s = ptr_r;
        end
        pick_s        = rr_select(MAX_REQ'(bus.req), INPUTS, 32'(start_s));
        pick_sel_s    = SEL'(pick_s.idx);
        pick_onehot_s = {{(INPUTS-1){1'b0}}, 1'b1} << pick_sel_s;
        hold_s        = bus.req[sel_r] && (hold_cnt_r < HOLD_W'(MAX_HOLD - 1));
    end

    // Arbitration FSM with registered grant, select and valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ARB_IDLE;
            ptr_r         <= {SEL{1'b0}};
            sel_r         <= {SEL{1'b0}};
            grant_r       <= {INPUTS{1'b0}};
            grant_valid_r <= 1'b0;
            hold_cnt_r    <= {HOLD_W{1'b0}};
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (pick_s.found) begin
                        state_r       <= ARB_GRANT;
                        sel_r         <= pick_sel_s;
                        grant_r       <= pick_onehot_s;
                        grant_valid_r <= 1'b1;
                        hold_cnt_r    <= {HOLD_W{1'b0}};
                    end else begin
                        state_r       <= ARB_IDLE;
                        grant_r       <= {INPUTS{1'b0}};
                        grant_valid_r <= 1'b0;
                    end
                end
                ARB_GRANT: begin
                    if (hold_s) begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                    end else begin
                        ptr_r      <= next_ptr_s;
                        hold_cnt_r <= {HOLD_W{1'b0}};
                        if (pick_s.found) begin
                            sel_r   <= pick_sel_s;
                            grant_r <= pick_onehot_s;
                        end else begin
                            state_r       <= ARB_IDLE;
                            grant_r       <= {INPUTS{1'b0}};
                            grant_valid_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r       <= ARB_IDLE;
                    grant_r       <= {INPUTS{1'b0}};
                    grant_valid_r <= 1'b0;
                    hold_cnt_r    <= {HOLD_W{1'b0}};
                end
            endcase
        end
    end

    mux #(
        .SEL    (SEL),
        .INPUTS (INPUTS)
    ) u_mux (
        .sel      (sel_r),
        .data_in  (bus.data_in),
        .data_out (mux_out_s)
    );

    assign bus.grant       = grant_r;
    assign bus.grant_valid = grant_valid_r;
    assign bus.sel         = sel_r;
    assign bus.data_out    = grant_valid_r & mux_out_s;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: a vector table on the default build plus
// hand sequences on MAX_HOLD=2 and INPUTS=5 builds.
module tb_mux_rr_arbiter;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic [15:0] din;
        logic [15:0] grant;
        logic        gv;
        logic [3:0]  sel;
        logic        dout;
    } vec_t;

    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.SEL(4), .INPUTS(16)) if0 ();
    mux_rr_arbiter_if #(.SEL(4), .INPUTS(16)) if1 ();
    mux_rr_arbiter_if #(.SEL(3), .INPUTS(5))  if2 ();

    mux_rr_arbiter #(.SEL(4), .INPUTS(16), .MAX_HOLD(8)) u0 (.clk(clk), .reset(rst0), .bus(if0.slave));
    mux_rr_arbiter #(.SEL(4), .INPUTS(16), .MAX_HOLD(2)) u1 (.clk(clk), .reset(rst1), .bus(if1.slave));
    mux_rr_arbiter #(.SEL(3), .INPUTS(5),  .MAX_HOLD(8)) u2 (.clk(clk), .reset(rst2), .bus(if2.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check2(input string tag, input logic [4:0] g, input logic gv,
                          input logic [2:0] s, input logic d);
        check({tag, " grant"}, 64'(if2.grant), 64'(g));
        check({tag, " gv"},    64'(if2.grant_valid), 64'(gv));
        check({tag, " sel"},   64'(if2.sel), 64'(s));
        check({tag, " dout"},  64'(if2.data_out), 64'(d));
        check({tag, " sel<=4"}, 64'(if2.sel <= 3'd4), 64'(1));
    endtask

    vec_t tbl[11];
    int   seq1[8];

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        if0.req = 16'h0000; if0.data_in = 16'h0000;
        if1.req = 16'h0000; if1.data_in = 16'h0000;
        if2.req = 5'b00000; if2.data_in = 5'b00000;

        tbl[0]  = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 4'd0,  1'b0};
        tbl[1]  = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 4'd0,  1'b0};
        tbl[2]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 4'd0,  1'b1};
        tbl[3]  = '{1'b0, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 4'd0,  1'b0};
        tbl[4]  = '{1'b0, 16'h0020, 16'h0020, 16'h0020, 1'b1, 4'd5,  1'b1};
        tbl[5]  = '{1'b0, 16'h0020, 16'h0000, 16'h0020, 1'b1, 4'd5,  1'b0};
        tbl[6]  = '{1'b0, 16'h0020, 16'h0020, 16'h0020, 1'b1, 4'd5,  1'b1};
        tbl[7]  = '{1'b0, 16'h0000, 16'h0020, 16'h0000, 1'b0, 4'd5,  1'b0};
        tbl[8]  = '{1'b0, 16'h8000, 16'h0000, 16'h8000, 1'b1, 4'd15, 1'b0};
        tbl[9]  = '{1'b0, 16'h0002, 16'h0002, 16'h0002, 1'b1, 4'd1,  1'b1};
        tbl[10] = '{1'b0, 16'h0000, 16'h0002, 16'h0000, 1'b0, 4'd1,  1'b0};

        for (int i = 0; i < 11; i++) begin
            rst0        = tbl[i].rst;
            if0.req     = tbl[i].req;
            if0.data_in = tbl[i].din;
            step();
            check($sformatf("row%0d grant", i), 64'(if0.grant), 64'(tbl[i].grant));
            check($sformatf("row%0d gv", i),    64'(if0.grant_valid), 64'(tbl[i].gv));
            check($sformatf("row%0d sel", i),   64'(if0.sel), 64'(tbl[i].sel));
            check($sformatf("row%0d dout", i),  64'(if0.data_out), 64'(tbl[i].dout));
        end

        // Lone requester 8 held for 20 cycles: grant never drops, hold count wraps mod 8.
        if0.req = 16'h0100;
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("lone%0d sel", k),  64'(if0.sel), 64'(8));
            check($sformatf("lone%0d gv", k),   64'(if0.grant_valid), 64'(1));
            check($sformatf("lone%0d hold", k), 64'(u0.hold_cnt_r), 64'(k % 8));
        end
        if0.req = 16'h0000;
        step();
        check("lone end gv", 64'(if0.grant_valid), 64'(0));

        // Requester 15 holds to expiry while 1 waits: handover wraps to 1.
        if0.req = 16'h8002;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("exp%0d sel", k), 64'(if0.sel), 64'(15));
        end
        step();
        check("exp wrap sel", 64'(if0.sel), 64'(1));
        check("exp wrap grant", 64'(if0.grant), 64'(16'h0002));
        check("exp wrap gv", 64'(if0.grant_valid), 64'(1));
        if0.req = 16'h0000;

        // MAX_HOLD=2 round robin between 0 and 3.
        seq1 = '{0, 0, 3, 3, 0, 0, 3, 3};
        if1.req = 16'h0009;
        rst1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("rr%0d sel", k), 64'(if1.sel), 64'(seq1[k]));
            check($sformatf("rr%0d gv", k),  64'(if1.grant_valid), 64'(1));
            check($sformatf("rr%0d grant", k), 64'(if1.grant), 64'(16'h0001) << seq1[k]);
        end

        // INPUTS=5: grant at 4, reset mid-grant, restart from 0, pointer wrap.
        if2.data_in = 5'b00001;
        if2.req = 5'b10000;
        rst2 = 1'b0;
        step();
        check2("n5 at4", 5'b10000, 1'b1, 3'd4, 1'b0);
        rst2 = 1'b1;
        if2.req = 5'b10001;
        step();
        check2("n5 rst", 5'b00000, 1'b0, 3'd0, 1'b0);
        rst2 = 1'b0;
        step();
        check2("n5 post", 5'b00001, 1'b1, 3'd0, 1'b1);
        if2.req = 5'b10000;
        step();
        check2("n5 to4", 5'b10000, 1'b1, 3'd4, 1'b0);
        if2.req = 5'b00001;
        step();
        check2("n5 wrap", 5'b00001, 1'b1, 3'd0, 1'b1);
        if2.req = 5'b00000;
        step();
        check2("n5 idle", 5'b00000, 1'b0, 3'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one `mux` datapath between up to INPUTS requesters. It owns the mux `sel` line: it grants one requester at a time, steers that requester's `data_in` bit to `data_out`, and rotates priority after each release. A per-grant hold limit prevents any requester from starving the rest. The block sits between the routing-fabric clients and the shared mux, and replaces static `sel` wiring wherever a mux input is time-shared.

## Interface
- `SEL`, 4, width of the select / grant index
- `INPUTS`, 16, number of requesters and mux inputs; must satisfy 2 ≤ INPUTS ≤ 2**SEL
- `MAX_HOLD`, 8, maximum consecutive cycles a single grant may last; must be ≥ 1

- `clk`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `req`  in  INPUTS  request vector; bit i is held high while requester i wants the mux
- `data_in`  in  INPUTS  mux data inputs, one bit per requester
- `grant`  out  INPUTS  one-hot registered grant; all zero when idle
- `grant_valid`  out  1  high while any grant is active
- `sel`  out  SEL  registered binary index of the granted requester; drives the mux
- `data_out`  out  1  `data_in[sel]` when `grant_valid` is high, otherwise 0

## Operation
- **State machine:** two states, IDLE and GRANT. Internal state:
  - `ptr`: priority pointer, range 0..INPUTS-1.
  - `hold_cnt`: hold counter, 0..MAX_HOLD-1.
- **Selection function:** scans `req` from index `ptr` upward, wrapping from INPUTS-1 to 0, and picks the first set bit. Bits at or above INPUTS do not exist and are never selected.
- **IDLE:**
  - Any `req` bit high → GRANT.
  - `sel` and `grant` take the selected index; `hold_cnt` is set to 0.
  - No `req` bit high → remain in IDLE with all outputs at their idle values.
- **GRANT, hold:** if `req[sel]` is high and `hold_cnt` < MAX_HOLD-1:
  - Keep the grant unchanged.
  - Increment `hold_cnt`.
- **GRANT, release:** occurs when `req[sel]` is low, or when `hold_cnt` == MAX_HOLD-1.
  - Set `ptr` to `sel`+1, wrapping at INPUTS to 0.
  - Run the selection function in the same cycle, starting from the new `ptr`.
  - If a requester is found, grant it on the next edge with no idle bubble and reset `hold_cnt` to 0.
  - If no requester is found → IDLE.
- **Expiry with a single requester:** when the hold expires and the current holder is the only requester, the search wraps back to it and it is re-granted. `hold_cnt` restarts at 0.
- **Simultaneous events:**
  - A release and new requests in the same cycle: arbitration uses the `req` value of that cycle.
  - A holder that drops its request while others rise: the grant goes to the next requester at or after `sel`+1.
- **Data path:**
  - `data_out` is combinational from `sel` and `data_in` through the `mux` instance.
  - `data_out` is gated to 0 when `grant_valid` is low.

## Timing
- **Reset values:** while `reset` is high at an edge:
  - `grant` = 0, `grant_valid` = 0, `sel` = 0, `ptr` = 0, `hold_cnt` = 0, state IDLE.
  - `data_out` = 0.
- **Reset mid-grant:** the grant drops on the reset edge. The first arbitration after reset starts from index 0.
- **Grant latency:** `req` is sampled at edge k; `grant`, `sel` and `grant_valid` are valid after edge k, which is 1 cycle of latency.
- **Handover:** back-to-back, with zero idle cycles between successive grants whenever requests are pending.
- **Hold limit:** a single grant keeps `grant_valid` high with an unchanged `sel` for at most MAX_HOLD consecutive cycles.
- **Output stability:**
  - `grant` is always one-hot or zero.
  - `sel` is always equal to the index of the set `grant` bit while granted.
  - `sel` holds its last value while idle.

## Structure
- **Package `mux_arb_pkg`:**
  - State encoding localparams `ST_IDLE` and `ST_GRANT`.
  - A rotate-priority-select function (request vector, start index → found flag, index).
  - Shared with future arbiters in the fabric.
- **Sub-module:** the existing `mux` (SEL, INPUTS) is instantiated once for the data path, with `sel` driven by this block's register.
- **Elaboration checks:** fail on INPUTS > 2**SEL, INPUTS < 2, or MAX_HOLD < 1.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `req` = 16'hFFFF → `grant` = 0, `grant_valid` = 0, `sel` = 0, `data_out` = 0 throughout. Release reset → `grant` = 16'h0001 one cycle later.
- **Single requester:** `req` = 16'h0020 for 3 cycles, then 0 → `sel` = 5 for 3 cycles starting 1 cycle after the request, then IDLE. `data_out` follows `data_in[5]` only while granted.
- **Round robin:** `req` = 16'h0009 held constantly with MAX_HOLD = 2 → grant sequence 0,0,3,3,0,0,3,3 with no idle gaps.
- **Wrap-around:** after requester 15 is granted and releases, with `req` = 16'h8002 → next grant is 1, not 15.
- **Hold expiry with a lone requester:** `req` = 16'h0100 held for 20 cycles with MAX_HOLD = 8 → `sel` stays 8 and `grant_valid` stays high, with `hold_cnt` wrapping every 8 cycles.
- **Reset mid-grant and non-power-of-two width:** with INPUTS = 5, SEL = 3:
  - Granted at index 4, then `reset` pulsed → outputs zero; after reset, `req` = 5'b10001 is granted to 0 first.
  - Pointer wraps from 4 to 0 and never yields `sel` > 4.
